// File: rtl/uart_tx_framer.sv
// UART transmit framer: latches a byte into an 11-bit frame (start, 8 data LSB first,
// parity, stop) and shifts it out on tx_out, holding each bit for CLKS_PER_BIT cycles.
module uart_tx_framer #(
  parameter int CLKS_PER_BIT = 16,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tx_start,
  input  logic [7:0]  data_in,
  output logic        tx_out,
  output logic        busy,
  output logic        done_flag,
  output logic [10:0] frame_out
);

  localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [10:0]      frame_q;
  logic             tx_q;
  logic             busy_q;
  logic             done_q;
  logic             bit_end;

  function automatic logic parity_of(input logic [7:0] d);
    return (^d) ^ PARITY_ODD;
  endfunction

  assign bit_end = (cnt_q == CNT_MAX);

  // Baud counter: held at zero while idle, wraps at the end of every bit period.
  always_comb begin
    cnt_d = cnt_q;
    if ((state_q == IDLE) || bit_end) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Frame sequencer with registered line and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= 3'd0;
      shift_q   <= 8'h00;
      frame_q   <= 11'h7FE;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tx_start) begin
            state_q   <= START;
            frame_q   <= {1'b1, parity_of(data_in), data_in, 1'b0};
            shift_q   <= data_in;
            bit_idx_q <= 3'd0;
            tx_q      <= 1'b0;
            busy_q    <= 1'b1;
          end
        end
        START: begin
          if (bit_end) begin
            state_q <= DATA;
            tx_q    <= shift_q[0];
          end
        end
        DATA: begin
          // Data bits come from a private shift copy so the next bit is always at [1].
          if (bit_end) begin
            if (bit_idx_q == 3'd7) begin
              state_q <= PARITY;
              tx_q    <= frame_q[9];
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
              shift_q   <= {1'b0, shift_q[7:1]};
              tx_q      <= shift_q[1];
            end
          end
        end
        PARITY: begin
          if (bit_end) begin
            state_q <= STOP;
            tx_q    <= 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            state_q <= IDLE;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          tx_q    <= 1'b1;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign tx_out    = tx_q;
  assign busy      = busy_q;
  assign done_flag = done_q;
  assign frame_out = frame_q;

endmodule

// File: doc/uart_tx_framer.md
Name: uart_tx_framer

Overview:
UART transmit path, the counterpart of the receive-side deframer. It accepts an 8-bit byte on a start strobe and builds an 11-bit frame: start bit, 8 data bits LSB first, parity, stop. It serialises the frame on tx_out at a fixed bit period derived from the system clock, and reports busy/done status to the host. frame_out uses the same bit layout the deframer expects, so the two blocks can be looped back directly.

Parameters:
CLKS_PER_BIT, 16, clock cycles per serial bit; legal range >= 2.
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
tx_start  input  1  request to send data_in; sampled only while idle.
data_in  input  8  byte to transmit.
tx_out  output  1  serial line; idles high.
busy  output  1  high while a frame is in flight.
done_flag  output  1  one-cycle pulse after the stop bit completes.
frame_out  output  11  latched frame: [0]=start(0), [8:1]=data, [9]=parity, [10]=stop(1).

Behaviour:
- Reset (synchronous, active-high):
  - On the first edge with reset=1: tx_out=1, busy=0, done_flag=0, frame_out=11'h7FE (idle pattern).
  - State goes to IDLE; baud counter and bit index clear.
- Reset takes effect on the next edge even mid-frame: the frame is abandoned, tx_out returns high, and no done_flag is produced.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE -> START on an edge with tx_start=1:
  - data_in is captured.
  - parity = XOR(data_in) XOR PARITY_ODD.
  - frame_out is loaded with {1'b1, parity, data_in, 1'b0}.
  - From the next cycle: busy=1 and tx_out=0.
- Every bit is held for exactly CLKS_PER_BIT cycles. The baud counter runs 0..CLKS_PER_BIT-1 and wraps; the state or bit advances on the wrap.
- START -> DATA after one bit period.
- DATA transmits frame_out[1] through frame_out[8]; the bit index runs 0..7. DATA -> PARITY after index 7 wraps.
- PARITY drives frame_out[9] for one bit period, then -> STOP.
- STOP drives 1 for one bit period, then -> IDLE.
- On the IDLE entry cycle after STOP: done_flag=1 for exactly one cycle, busy=0, tx_out=1.
- Total time from tx_start acceptance to the done_flag cycle: 11*CLKS_PER_BIT + 1 edges.
- tx_start while busy=1 is ignored; data_in changes during a frame have no effect.
- Back-to-back: tx_start=1 during the done_flag cycle is accepted. The line then stays high for exactly that one cycle between frames.
- frame_out holds the last frame until the next accepted tx_start or reset.
- done_flag is never asserted together with busy.

Test Plan:
1. Reset: assert reset 3 cycles mid-stream -> tx_out=1, busy=0, done_flag=0, frame_out=11'h7FE; the edge after release is still idle.
2. CLKS_PER_BIT=4, PARITY_ODD=0, send 0xA5:
   - frame_out=11'h54A.
   - tx_out sequence, 4 cycles per bit: 0,1,0,1,0,0,1,0,1,0,1.
   - busy high for 44 cycles, then done_flag pulses once.
3. Parity: send 0x07 -> parity bit 1 with PARITY_ODD=0 and 0 with PARITY_ODD=1; send 0x00 with even parity -> parity 0, frame_out=11'h400.
4. Busy ignore: start 0x3C, pulse tx_start with data_in=0xFF at cycle 10 -> transmitted bits and frame_out still match 0x3C; only one done_flag.
5. Back-to-back: assert tx_start with 0x55 in the done_flag cycle of a 0xAA frame -> exactly one idle-high cycle, then start bit 0; each frame is followed by its own done_flag.
6. Reset mid-frame: reset during DATA bit 3 -> tx_out=1 next edge, no done_flag; a new 0x81 frame afterwards is transmitted correctly.
